rate_tick_gen: RTL and testbench
================================

Name: rate_tick_gen

Overview:
- Front end for the 8-bit up/down LED counter. Sits directly upstream of it and produces the count-enable tick plus clean rate-select and direction controls.
- Synchronises and debounces the raw board switches `sw_raw[1:0]` and `ud_raw`.
- Generates a single-cycle `tick` at 100 / 10 / 1 / 0.1 Hz from the 50 MHz board clock.
- Restarts the rate divider cleanly whenever the debounced rate selection changes.

Parameters:
- BASE_DIV, 50000, clk cycles per 1 kHz base tick (50 MHz / 1 kHz)
- DEB_CYC, 500000, cycles a changed input must stay stable before commit (10 ms)
- SW_RST, 2'b11, reset value of `sw_q`

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- sw_raw  in  2  raw rate-select switches (asynchronous to clk)
- ud_raw  in  1  raw direction switch, 1 = up (asynchronous to clk)
- tick  out  1  one-cycle count enable for the counter stage
- sw_q  out  2  debounced rate select
- ud_q  out  1  debounced direction
- rate_chg  out  1  one-cycle pulse when `sw_q` commits a new value

Behaviour:
- Reset: asynchronous and active-low (`reset` = 0 resets immediately, independent of clk).
- Reset values:
  - `tick` = 0, `rate_chg` = 0
  - `sw_q` = SW_RST, `ud_q` = 1
  - all counters = 0; synchronisers and debounce candidate loaded with {SW_RST, 1}.
- Synchroniser: 2-FF chain on each of the 3 raw bits. Synced value `s` lags the raw input by 2 cycles.
- Debounce (3-bit vector, single shared counter `deb_cnt`):
  - if `s` != candidate: candidate <= `s`, `deb_cnt` <= 0
  - else if candidate != {`sw_q`,`ud_q`}: `deb_cnt` increments; when `deb_cnt` == DEB_CYC-1, commit {`sw_q`,`ud_q`} <= candidate and clear `deb_cnt`
  - any bounce shorter than DEB_CYC cycles is ignored
  - commit latency from a clean raw edge = 2 + 1 + DEB_CYC cycles.
- Base prescaler:
  - `base_cnt` counts 0..BASE_DIV-1 and wraps.
  - `base_tick` (internal) is true when `base_cnt` == BASE_DIV-1.
- Rate counter `rate_cnt` (14 bits):
  - increments on `base_tick`; terminal N selected by `sw_q`: 3→10, 2→100, 1→1000, 0→10000.
  - `tick` is registered: asserted the cycle after `base_tick` && `rate_cnt` == N-1; `rate_cnt` wraps to 0 at the same point.
- Period: exactly BASE_DIV*N cycles between `tick` rising edges. First `tick` after reset release is on cycle BASE_DIV*N, counting the first clk edge after release as cycle 1.
- Rate change:
  - on the cycle `sw_q` commits a different value, `base_cnt` <= 0, `rate_cnt` <= 0, `tick` <= 0, and `rate_chg` pulses high the next cycle.
  - first new-rate `tick` comes BASE_DIV*N_new cycles after the commit; no partial or short periods.
- Direction change: a `ud_q` commit does not disturb the counters, `tick`, or `rate_chg`.
- Simultaneous commit of `sw_q` and `ud_q` (same cycle): counter restart as for a rate change, `rate_chg` pulses once.
- Commit coinciding with the terminal-count cycle: the restart wins; no `tick` is issued for that period.
- Reset mid-period: all state returns to reset values immediately; no `tick` is produced while `reset` = 0.
- `tick` is never wider than 1 cycle, and never asserted on consecutive cycles.

Optional Feature:
- RATE_HOLD_EN defined:
  - adds input port `hold` (1 bit, synchronous, not debounced).
  - while `hold` = 1: `base_cnt` and `rate_cnt` freeze and `tick` = 0; the debounce path keeps running.
  - on `hold` 1→0: counting resumes from the frozen values, so the remaining period is preserved.
  - a rate commit during hold still clears the counters and pulses `rate_chg`.
- RATE_HOLD_EN undefined: no `hold` port; counters run unconditionally.

Test Plan (bench overrides BASE_DIV=10, DEB_CYC=4; 20 ns clk):
- Reset low 3 cycles, then high with `sw_raw`=3 held -> `sw_q`=3, `ud_q`=1, `rate_chg` never pulses; ticks on cycles 100, 200, 300 after release.
- `sw_raw` 3→2 clean at cycle 150 -> commit at cycle 157, `rate_chg` pulse at 158; next `tick` at cycle 1157, then every 1000 cycles.
- `sw_raw` toggles with 2-cycle glitches for 20 cycles, then returns to the original value -> `sw_q` unchanged, no `rate_chg`, `tick` spacing unaffected.
- `ud_raw` 1→0 mid-period at `sw_q`=3 -> `ud_q`=0 after 7 cycles; `tick` spacing stays exactly 100 cycles.
- Assert `reset`=0 asynchronously 40 cycles into a period (between edges) -> all outputs 0 / reset values immediately; after release, first `tick` at cycle 100.
- With RATE_HOLD_EN: `hold`=1 for 25 cycles starting 30 cycles after a `tick` -> next `tick` arrives 125 cycles after the previous one; no `tick` while `hold`=1.

Source files
------------

// File: rtl/rate_tick_gen.sv
// -----------------------------------------------------------------------------
// rate_tick_gen
// Front end for the 8-bit up/down LED counter. It synchronises and debounces
// the raw rate-select and direction switches. From those it produces a
// single-cycle count-enable tick at 100 / 10 / 1 / 0.1 Hz, derived from the
// 50 MHz board clock.
//
// Ports:
//   clk       in   system clock (50 MHz)
//   reset     in   asynchronous, active-low reset
//   sw_raw    in   [1:0] raw rate-select switches (asynchronous to clk)
//   ud_raw    in   raw direction switch, 1 = up (asynchronous to clk)
//   hold      in   (RATE_HOLD_EN only) synchronous freeze of the rate divider
//   tick      out  one-cycle count enable for the counter stage
//   sw_q      out  [1:0] debounced rate select
//   ud_q      out  debounced direction
//   rate_chg  out  one-cycle pulse, one cycle after sw_q commits a new value
//
// Build option:
//   RATE_HOLD_EN  adds the hold input. While hold is high the base prescaler
//                 and the rate counter freeze, and tick stays low. Debouncing
//                 keeps running while hold is high.
// -----------------------------------------------------------------------------
module rate_tick_gen #(
  parameter int unsigned BASE_DIV = 50000,
  parameter int unsigned DEB_CYC  = 500000,
  parameter logic [1:0]  SW_RST   = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_raw,
  input  logic       ud_raw,
`ifdef RATE_HOLD_EN
  input  logic       hold,
`endif
  output logic       tick,
  output logic [1:0] sw_q,
  output logic       ud_q,
  output logic       rate_chg
);

  localparam int unsigned BASE_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam int unsigned DEB_W  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(BASE_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [2:0]        RST_VEC   = {SW_RST, 1'b1};

  // Last rate_cnt value of a period (N-1) for each rate selection
  function automatic logic [13:0] rate_last(input logic [1:0] sel);
    logic [13:0] last;
    case (sel)
      2'd3:    last = 14'd9;
      2'd2:    last = 14'd99;
      2'd1:    last = 14'd999;
      2'd0:    last = 14'd9999;
      default: last = 14'd9999;
    endcase
    return last;
  endfunction

  logic [2:0]        sync1_r;
  logic [2:0]        sync2_r;
  logic [2:0]        cand_r;
  logic [DEB_W-1:0]  deb_cnt_r;
  logic [BASE_W-1:0] base_cnt_r;
  logic [13:0]       rate_cnt_r;
  logic              rate_chg_pend_r;

  logic [2:0]        cand_nxt_s;
  logic [DEB_W-1:0]  deb_cnt_nxt_s;
  logic              commit_s;
  logic              rate_commit_s;
  logic              base_tick_s;
  logic              hold_s;
  logic [BASE_W-1:0] base_cnt_nxt_s;
  logic [13:0]       rate_cnt_nxt_s;
  logic              tick_nxt_s;

`ifdef RATE_HOLD_EN
  assign hold_s = hold;
`else
  assign hold_s = 1'b0;
`endif

  assign base_tick_s = (base_cnt_r == BASE_LAST);
  // Only a change of the rate bits restarts the divider; a direction-only
  // commit leaves the period untouched.
  assign rate_commit_s = commit_s && (cand_r[2:1] != sw_q);

  // Two-flop synchroniser on {sw_raw, ud_raw}
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= RST_VEC;
      sync2_r <= RST_VEC;
    end else begin
      sync1_r <= {sw_raw, ud_raw};
      sync2_r <= sync1_r;
    end
  end

  // Debounce decision: restart on any change, commit after DEB_CYC stable cycles
  always_comb begin
    cand_nxt_s    = cand_r;
    deb_cnt_nxt_s = deb_cnt_r;
    commit_s      = 1'b0;
    if (sync2_r != cand_r) begin
      cand_nxt_s    = sync2_r;
      deb_cnt_nxt_s = '0;
    end else if (cand_r != {sw_q, ud_q}) begin
      if (deb_cnt_r == DEB_LAST) begin
        commit_s      = 1'b1;
        deb_cnt_nxt_s = '0;
      end else begin
        deb_cnt_nxt_s = deb_cnt_r + DEB_W'(1);
      end
    end else begin
      deb_cnt_nxt_s = deb_cnt_r;
    end
  end

  // Debounce state and committed switch outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_r    <= RST_VEC;
      deb_cnt_r <= '0;
      sw_q      <= SW_RST;
      ud_q      <= 1'b1;
    end else begin
      cand_r    <= cand_nxt_s;
      deb_cnt_r <= deb_cnt_nxt_s;
      if (commit_s) begin
        {sw_q, ud_q} <= cand_r;
      end
    end
  end

  // Divider next state: a rate restart beats hold and the terminal count
  always_comb begin
    base_cnt_nxt_s = base_cnt_r;
    rate_cnt_nxt_s = rate_cnt_r;
    tick_nxt_s     = 1'b0;
    if (rate_commit_s) begin
      base_cnt_nxt_s = '0;
      rate_cnt_nxt_s = 14'd0;
      tick_nxt_s     = 1'b0;
    end else if (hold_s) begin
      base_cnt_nxt_s = base_cnt_r;
      rate_cnt_nxt_s = rate_cnt_r;
      tick_nxt_s     = 1'b0;
    end else if (base_tick_s) begin
      base_cnt_nxt_s = '0;
      if (rate_cnt_r == rate_last(sw_q)) begin
        rate_cnt_nxt_s = 14'd0;
        tick_nxt_s     = 1'b1;
      end else begin
        rate_cnt_nxt_s = rate_cnt_r + 14'd1;
      end
    end else begin
      base_cnt_nxt_s = base_cnt_r + BASE_W'(1);
    end
  end

  // Divider registers and the registered tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_cnt_r <= '0;
      rate_cnt_r <= 14'd0;
      tick       <= 1'b0;
    end else begin
      base_cnt_r <= base_cnt_nxt_s;
      rate_cnt_r <= rate_cnt_nxt_s;
      tick       <= tick_nxt_s;
    end
  end

  // rate_chg is delayed one cycle behind the sw_q update through a pending flop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate_chg_pend_r <= 1'b0;
      rate_chg        <= 1'b0;
    end else begin
      rate_chg_pend_r <= rate_commit_s;
      rate_chg        <= rate_chg_pend_r;
    end
  end

endmodule

// File: tb/tb_rate_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_rate_tick_gen
// Directed bench for rate_tick_gen, built with BASE_DIV=10 and DEB_CYC=4.
// Cycle k means the state after the k-th rising edge following reset release.
// Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_rate_tick_gen;

  logic       clk;
  logic       reset;
  logic [1:0] sw_raw;
  logic       ud_raw;
`ifdef RATE_HOLD_EN
  logic       hold;
`endif
  logic       tick;
  logic [1:0] sw_q;
  logic       ud_q;
  logic       rate_chg;

  int n_checks = 0;
  int n_fail   = 0;

  rate_tick_gen #(
    .BASE_DIV(10),
    .DEB_CYC (4),
    .SW_RST  (2'b11)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_raw  (sw_raw),
    .ud_raw  (ud_raw),
`ifdef RATE_HOLD_EN
    .hold    (hold),
`endif
    .tick    (tick),
    .sw_q    (sw_q),
    .ud_q    (ud_q),
    .rate_chg(rate_chg)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Reset for 3 cycles, then release between edges; cycle 0 follows release.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    sw_raw = 2'b11;
    ud_raw = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%0b exp=0", tick); end
    n_checks++;
    if (rate_chg !== 1'b0) begin n_fail++; $display("FAIL reset_rate_chg got=%0b exp=0", rate_chg); end
    n_checks++;
    if (sw_q !== 2'b11) begin n_fail++; $display("FAIL reset_sw_q got=%0d exp=3", sw_q); end
    n_checks++;
    if (ud_q !== 1'b1) begin n_fail++; $display("FAIL reset_ud_q got=%0b exp=1", ud_q); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      logic exp_tick;
      @(posedge clk);
      @(negedge clk);
      exp_tick = (k % 100 == 0);
      n_checks++;
      if (tick !== exp_tick) begin n_fail++; $display("FAIL base_tick cyc=%0d got=%0b exp=%0b", k, tick, exp_tick); end
      n_checks++;
      if (rate_chg !== 1'b0 || sw_q !== 2'b11 || ud_q !== 1'b1) begin
        n_fail++; $display("FAIL base_ctrl cyc=%0d got rc=%0b sw=%0d ud=%0b exp rc=0 sw=3 ud=1", k, rate_chg, sw_q, ud_q);
      end
    end
  endtask

  task automatic test_rate_change();
    sw_raw = 2'b11;
    ud_raw = 1'b1;
    apply_reset();
    for (int k = 1; k <= 2200; k++) begin
      logic       exp_tick;
      logic       exp_rc;
      logic [1:0] exp_sw;
      @(posedge clk);
      @(negedge clk);
      exp_tick = (k == 100) || (k == 1157) || (k == 2157);
      exp_rc   = (k == 158);
      exp_sw   = (k >= 157) ? 2'd2 : 2'd3;
      n_checks++;
      if (tick !== exp_tick) begin n_fail++; $display("FAIL rchg_tick cyc=%0d got=%0b exp=%0b", k, tick, exp_tick); end
      n_checks++;
      if (rate_chg !== exp_rc) begin n_fail++; $display("FAIL rchg_pulse cyc=%0d got=%0b exp=%0b", k, rate_chg, exp_rc); end
      n_checks++;
      if (sw_q !== exp_sw) begin n_fail++; $display("FAIL rchg_sw_q cyc=%0d got=%0d exp=%0d", k, sw_q, exp_sw); end
      if (k == 150) sw_raw = 2'b10;
    end
  endtask

  task automatic test_glitch();
    sw_raw = 2'b11;
    ud_raw = 1'b1;
    apply_reset();
    for (int k = 1; k <= 400; k++) begin
      logic exp_tick;
      @(posedge clk);
      @(negedge clk);
      exp_tick = (k % 100 == 0);
      n_checks++;
      if (tick !== exp_tick) begin n_fail++; $display("FAIL glitch_tick cyc=%0d got=%0b exp=%0b", k, tick, exp_tick); end
      n_checks++;
      if (sw_q !== 2'b11 || rate_chg !== 1'b0) begin
        n_fail++; $display("FAIL glitch_ctrl cyc=%0d got sw=%0d rc=%0b exp sw=3 rc=0", k, sw_q, rate_chg);
      end
      if (k >= 120 && k < 140) sw_raw = (((k - 120) / 2) % 2 == 1) ? 2'b11 : 2'b10;
      else sw_raw = 2'b11;
    end
  endtask

  task automatic test_direction();
    sw_raw = 2'b11;
    ud_raw = 1'b1;
    apply_reset();
    for (int k = 1; k <= 300; k++) begin
      logic exp_tick;
      logic exp_ud;
      @(posedge clk);
      @(negedge clk);
      exp_tick = (k % 100 == 0);
      exp_ud   = (k >= 147) ? 1'b0 : 1'b1;
      n_checks++;
      if (tick !== exp_tick) begin n_fail++; $display("FAIL dir_tick cyc=%0d got=%0b exp=%0b", k, tick, exp_tick); end
      n_checks++;
      if (ud_q !== exp_ud) begin n_fail++; $display("FAIL dir_ud_q cyc=%0d got=%0b exp=%0b", k, ud_q, exp_ud); end
      n_checks++;
      if (rate_chg !== 1'b0 || sw_q !== 2'b11) begin
        n_fail++; $display("FAIL dir_ctrl cyc=%0d got rc=%0b sw=%0d exp rc=0 sw=3", k, rate_chg, sw_q);
      end
      if (k == 140) ud_raw = 1'b0;
    end
    ud_raw = 1'b1;
  endtask

  task automatic test_async_reset();
    sw_raw = 2'b11;
    ud_raw = 1'b1;
    apply_reset();
    for (int k = 1; k <= 140; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 20) ud_raw = 1'b0;
    end
    n_checks++;
    if (ud_q !== 1'b0) begin n_fail++; $display("FAIL arst_pre_ud_q got=%0b exp=0", ud_q); end
    #3;
    reset  = 1'b0;
    ud_raw = 1'b1;
    #1;
    n_checks++;
    if (tick !== 1'b0 || rate_chg !== 1'b0) begin
      n_fail++; $display("FAIL arst_pulses got tick=%0b rc=%0b exp 0 0", tick, rate_chg);
    end
    n_checks++;
    if (sw_q !== 2'b11 || ud_q !== 1'b1) begin
      n_fail++; $display("FAIL arst_switches got sw=%0d ud=%0b exp sw=3 ud=1", sw_q, ud_q);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (tick !== 1'b0) begin n_fail++; $display("FAIL arst_hold_tick step=%0d got=%0b exp=0", i, tick); end
    end
    reset = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      logic exp_tick;
      @(posedge clk);
      @(negedge clk);
      exp_tick = (k == 100);
      n_checks++;
      if (tick !== exp_tick) begin n_fail++; $display("FAIL arst_tick cyc=%0d got=%0b exp=%0b", k, tick, exp_tick); end
      n_checks++;
      if (ud_q !== 1'b1) begin n_fail++; $display("FAIL arst_ud_q cyc=%0d got=%0b exp=1", k, ud_q); end
    end
  endtask

`ifdef RATE_HOLD_EN
  task automatic test_hold();
    sw_raw = 2'b11;
    ud_raw = 1'b1;
    hold   = 1'b0;
    apply_reset();
    for (int k = 1; k <= 330; k++) begin
      logic exp_tick;
      @(posedge clk);
      @(negedge clk);
      exp_tick = (k == 100) || (k == 225) || (k == 325);
      n_checks++;
      if (tick !== exp_tick) begin n_fail++; $display("FAIL hold_tick cyc=%0d got=%0b exp=%0b", k, tick, exp_tick); end
      hold = (k >= 130 && k < 155) ? 1'b1 : 1'b0;
    end
    hold = 1'b0;
  endtask
`endif

  initial begin
    reset  = 1'b0;
    sw_raw = 2'b11;
    ud_raw = 1'b1;
`ifdef RATE_HOLD_EN
    hold   = 1'b0;
`endif
    test_reset();
    test_rate_change();
    test_glitch();
    test_direction();
    test_async_reset();
`ifdef RATE_HOLD_EN
    test_hold();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
